// File: rtl/modexp_mont_param.sv
// a^b mod m by right-to-left square-and-multiply in the Montgomery domain (R = 2^WIDTH).
// Define MODEXP_MONT_OUT_EN to skip the final conversion and return a^b*R mod m.
module modexp_mont_param #(
    parameter int WIDTH     = 256,
    parameter int EXP_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [EXP_WIDTH-1:0] b,
    input  logic [WIDTH-1:0]     m,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 error
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] PRE_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MONT_LAST = CW'(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_PRE, S_EXP_TEST, S_MUL, S_SQR, S_POST, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     m_q, m_d, base_q, base_d, acc_q, acc_d;
    logic [WIDTH-1:0]     x_q, x_d, result_q, result_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [WIDTH+1:0]     t_q, t_d;
    logic                 error_q, error_d, ready_q;

    logic [WIDTH:0]       m_w1, base_dbl, acc_dbl;
    logic [WIDTH+1:0]     m_w2, t_add, t_odd;
    logic [WIDTH-1:0]     mont_y, mont_res;
    logic                 bad_operands;

    always_comb begin
        m_w1         = {1'b0, m_q};
        m_w2         = {2'b0, m_q};
        base_dbl     = {base_q, 1'b0};
        acc_dbl      = {acc_q, 1'b0};
        // POST multiplies by plain 1 to leave the Montgomery domain
        mont_y       = (state_q == S_POST) ? WIDTH'(1) : base_q;
        t_add        = t_q + (x_q[0] ? {2'b0, mont_y} : '0);
        t_odd        = t_add[0] ? t_add + m_w2 : t_add;
        mont_res     = (t_q >= m_w2) ? WIDTH'(t_q - m_w2) : t_q[WIDTH-1:0];
        bad_operands = !m_q[0] || (m_q < WIDTH'(3)) || (base_q >= m_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        base_d   = base_q;
        acc_d    = acc_q;
        x_d      = x_q;
        e_d      = e_q;
        t_d      = t_q;
        result_d = result_q;
        error_d  = error_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = a;
                    e_d     = b;
                    m_d     = m;
                    error_d = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_operands) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    acc_d   = WIDTH'(1);
                    cnt_d   = '0;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                base_d = (base_dbl >= m_w1) ? WIDTH'(base_dbl - m_w1) : base_dbl[WIDTH-1:0];
                acc_d  = (acc_dbl >= m_w1) ? WIDTH'(acc_dbl - m_w1) : acc_dbl[WIDTH-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EXP_TEST;
                end
            end
            S_EXP_TEST: begin
                cnt_d = '0;
                if (e_q == '0) begin
`ifdef MODEXP_MONT_OUT_EN
                    state_d = S_DONE;
`else
                    state_d = S_POST;
`endif
                end else if (e_q[0]) begin
                    state_d = S_MUL;
                end else begin
                    state_d = S_SQR;
                end
            end
            S_MUL, S_SQR, S_POST: begin
                // shared bit-serial multiplier: load, WIDTH steps, then one correction
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '0) begin
                    t_d = '0;
                    x_d = (state_q == S_SQR) ? base_q : acc_q;
                end else if (cnt_q != MONT_LAST) begin
                    t_d = t_odd >> 1;
                    x_d = x_q >> 1;
                end else begin
                    cnt_d = '0;
                    if (state_q == S_MUL) begin
                        acc_d   = mont_res;
                        state_d = S_SQR;
                    end else if (state_q == S_SQR) begin
                        base_d  = mont_res;
                        e_d     = e_q >> 1;
                        state_d = S_EXP_TEST;
                    end else begin
                        acc_d   = mont_res;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                result_d = acc_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            base_q   <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            e_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            base_q   <= base_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            e_q      <= e_d;
            t_q      <= t_d;
            result_q <= result_d;
            error_q  <= error_d;
            // done is held off for the first idle cycle after reset or completion
            ready_q  <= (state_q == S_IDLE);
        end
    end

    assign result = result_q;
    assign error  = error_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_IDLE) && ready_q && !start;

endmodule

// File: tb/tb_modexp_mont_param.sv
// Bench for modexp_mont_param: 8-bit vector table, corner sequences, 64-bit random regression.
module tb_modexp_mont_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start8, done8, busy8, err8;
    logic [7:0]  a8, b8, m8, res8;
    logic        start64, done64, busy64, err64;
    logic [63:0] a64, b64, m64, res64;

    modexp_mont_param #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .m(m8),
        .result(res8), .done(done8), .busy(busy8), .error(err8)
    );

    modexp_mont_param #(.WIDTH(64), .EXP_WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .a(a64), .b(b64), .m(m64),
        .result(res64), .done(done64), .busy(busy64), .error(err64)
    );

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        logic [7:0] res;
        logic       err;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl [0:10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    function automatic logic [63:0] modpow(input logic [63:0] ba, input logic [63:0] e,
                                           input logic [63:0] md);
        logic [127:0] r, x, mm;
        logic [63:0]  ee;
        mm = {64'b0, md};
        r  = 128'd1 % mm;
        x  = {64'b0, ba} % mm;
        ee = e;
        while (ee != 64'd0) begin
            if (ee[0]) r = (r * x) % mm;
            x  = (x * x) % mm;
            ee = ee >> 1;
        end
        return r[63:0];
    endfunction

    // Converts a plain residue into what the DUT reports for the current build.
    function automatic logic [63:0] out_form(input logic [63:0] r, input int w, input logic [63:0] md);
        logic [127:0] v;
        v = {64'b0, r};
`ifdef MODEXP_MONT_OUT_EN
        v = (v << w) % {64'b0, md};
`else
        if (w < 0) v = 128'd0;
`endif
        return v[63:0];
    endfunction

    function automatic int busy_cycles(input int w, input logic [63:0] e, input logic err);
        int n, p, c;
        n = 0;
        p = 0;
        if (err) return 1;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) begin
                n = i + 1;
                p++;
            end
        end
        c = 2 * w + 5 + n * (w + 3) + p * (w + 2);
`ifdef MODEXP_MONT_OUT_EN
        c = c - (w + 2);
`endif
        return c;
    endfunction

    // Drives one operation, counts busy cycles at negedges, then pops and compares.
    task automatic run(input bit wide, input bit synced, input bit hold,
                       input logic [63:0] ta, input logic [63:0] tb, input logic [63:0] tm,
                       input exp_t want, input string name);
        exp_t got_e;
        int   bc;
        bit   fin;
        bc  = 0;
        fin = 1'b0;
        sb_q.push_back(want);
        if (!synced) @(negedge clk);
        if (wide) begin
            a64 = ta; b64 = tb; m64 = tm; start64 = 1'b1;
        end else begin
            a8 = ta[7:0]; b8 = tb[7:0]; m8 = tm[7:0]; start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            start8  = 1'b0;
            start64 = 1'b0;
        end
        for (int k = 0; k < 20000 && !fin; k++) begin
            @(negedge clk);
            if (hold && k == 5) a8 = 8'd9;
            if (wide ? busy64 : busy8) bc++;
            else fin = 1'b1;
        end
        start8  = 1'b0;
        start64 = 1'b0;
        got_e = sb_q.pop_front();
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: busy still high after %0d cycles, required %0d", name, bc, got_e.cyc);
        end
        check({name, " result"}, wide ? res64 : {56'b0, res8}, got_e.res);
        check({name, " error"}, {63'b0, wide ? err64 : err8}, {63'b0, got_e.err});
        check({name, " busy_cycles"}, 64'(bc), 64'(got_e.cyc));
        $display("txn %s: a=%0d b=%0d m=%0d result=%0d error=%0b busy_cycles=%0d",
                 name, ta, tb, tm, wide ? res64 : {56'b0, res8}, wide ? err64 : err8, bc);
    endtask

    function automatic exp_t tbl_exp(input vec_t v);
        exp_t e;
        e.err = v.err;
        e.res = v.err ? 64'd0 : out_form({56'b0, v.res}, 8, {56'b0, v.m});
        e.cyc = busy_cycles(8, {56'b0, v.b}, v.err);
        return e;
    endfunction

    initial begin
        exp_t        e;
        logic [63:0] rm, ra, rb;

        tbl[0]  = '{a: 8'd2,   b: 8'd10,  m: 8'd251, res: 8'd20,  err: 1'b0};
        tbl[1]  = '{a: 8'd4,   b: 8'd13,  m: 8'd13,  res: 8'd4,   err: 1'b0};
        tbl[2]  = '{a: 8'd4,   b: 8'd0,   m: 8'd13,  res: 8'd1,   err: 1'b0};
        tbl[3]  = '{a: 8'd5,   b: 8'd3,   m: 8'd12,  res: 8'd0,   err: 1'b1};
        tbl[4]  = '{a: 8'd0,   b: 8'd3,   m: 8'd1,   res: 8'd0,   err: 1'b1};
        tbl[5]  = '{a: 8'd13,  b: 8'd2,   m: 8'd13,  res: 8'd0,   err: 1'b1};
        tbl[6]  = '{a: 8'd3,   b: 8'd5,   m: 8'd251, res: 8'd243, err: 1'b0};
        tbl[7]  = '{a: 8'd0,   b: 8'd5,   m: 8'd13,  res: 8'd0,   err: 1'b0};
        tbl[8]  = '{a: 8'd254, b: 8'd255, m: 8'd255, res: 8'd254, err: 1'b0};
        tbl[9]  = '{a: 8'd2,   b: 8'd1,   m: 8'd3,   res: 8'd2,   err: 1'b0};
        tbl[10] = '{a: 8'd0,   b: 8'd0,   m: 8'd13,  res: 8'd1,   err: 1'b0};

        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
        start64 = 1'b0; a64 = '0; b64 = '0; m64 = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset result", {56'b0, res8}, 64'd0);
        check("reset done", {63'b0, done8}, 64'd0);
        check("reset busy", {63'b0, busy8}, 64'd0);
        check("reset error", {63'b0, err8}, 64'd0);
        @(negedge clk);
        check("idle done", {63'b0, done8}, 64'd1);

        // vector table
        for (int i = 0; i < 11; i++) begin
            run(1'b0, 1'b0, 1'b0, {56'b0, tbl[i].a}, {56'b0, tbl[i].b}, {56'b0, tbl[i].m},
                tbl_exp(tbl[i]), $sformatf("vec%0d", i));
        end

        // start held high for the whole run, base changed mid-run
        run(1'b0, 1'b0, 1'b1, 64'd2, 64'd10, 64'd251, tbl_exp(tbl[0]), "hold_start");
        @(negedge clk);
        check("hold no restart busy", {63'b0, busy8}, 64'd0);
        check("first done cycle", {63'b0, done8}, 64'd1);
        // start on the first done-high cycle
        run(1'b0, 1'b1, 1'b0, 64'd4, 64'd13, 64'd13, tbl_exp(tbl[1]), "back_to_back");

        // reset in the middle of the first squaring
        @(negedge clk);
        a8 = 8'd2; b8 = 8'd10; m8 = 8'd251; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (14) @(negedge clk);
        check("pre-abort busy", {63'b0, busy8}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort result", {56'b0, res8}, 64'd0);
        check("abort done", {63'b0, done8}, 64'd0);
        check("abort busy", {63'b0, busy8}, 64'd0);
        check("abort error", {63'b0, err8}, 64'd0);
        run(1'b0, 1'b0, 1'b0, 64'd3, 64'd5, 64'd251, tbl_exp(tbl[6]), "after_abort");

        // 64-bit random regression against a software modpow
        for (int i = 0; i < 40; i++) begin
            rm = {$urandom, $urandom} | 64'd1;
            if (rm < 64'd3) rm = 64'd5;
            ra = {$urandom, $urandom} % rm;
            if (i == 0) ra = rm - 64'd1;
            rb = 64'($urandom_range(0, 255));
            if (i == 0) rb = 64'd255;
            e.err = 1'b0;
            e.res = out_form(modpow(ra, rb, rm), 64, rm);
            e.cyc = busy_cycles(64, rb, 1'b0);
            run(1'b1, 1'b0, 1'b0, ra, rb, rm, e, $sformatf("w64_%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
